// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills/write-backs, beat by beat.
// Build option: define CACHE_MEM_ARB_DPRIO_EN for fixed D-side priority; default is round-robin on ties.
`timescale 1ns/1ps
module cache_mem_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST_N,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              ireq_ready,
    output logic              iresp_valid,
    output logic [DATA_W-1:0] iresp_data,
    output logic              iresp_last,
    input  logic              dreq_valid,
    input  logic              dreq_we,
    input  logic [ADDR_W-1:0] dreq_addr,
    output logic              dreq_ready,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wpop,
    output logic              dresp_valid,
    output logic [DATA_W-1:0] dresp_data,
    output logic              dresp_last,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]              stateReg;
    logic [CNT_W-1:0]        cntReg;
    logic [ADDR_W-OFF_W-1:0] lineReg;
    logic                    ownerDReg;

    logic                    idleLive;
    logic                    pickD;
    logic                    grantI;
    logic                    grantD;
    logic [ADDR_W-OFF_W-1:0] reqLine;
    logic                    busy;
    logic                    rdBeat;
    logic                    wrBeat;
    logic                    lastBeat;
    logic                    unusedAddrBits;

    // Grants are gated by the reset pin so every output reads 0 while reset is held.
    assign idleLive = (stateReg == IDLE) && CPU_RST_N;

`ifdef CACHE_MEM_ARB_DPRIO_EN
    assign pickD = dreq_valid;
`else
    logic lastGrantDReg;

    // On a tie the side that did not win last time goes first.
    assign pickD = dreq_valid && (!ireq_valid || !lastGrantDReg);

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            lastGrantDReg <= 1'b0;
        end else if (grantI || grantD) begin
            lastGrantDReg <= grantD;
        end
    end
`endif

    assign grantD     = idleLive && pickD;
    assign grantI     = idleLive && ireq_valid && !pickD;
    assign ireq_ready = grantI;
    assign dreq_ready = grantD;

    // Only the line number is latched; the word offset comes from the beat counter.
    assign reqLine        = grantD ? dreq_addr[ADDR_W-1:OFF_W] : ireq_addr[ADDR_W-1:OFF_W];
    assign unusedAddrBits = ^{ireq_addr[OFF_W-1:0], dreq_addr[OFF_W-1:0]};

    assign busy     = (stateReg != IDLE);
    assign rdBeat   = (stateReg == RD_BURST) && mem_ready;
    assign wrBeat   = (stateReg == WR_BURST) && mem_ready;
    assign lastBeat = (rdBeat || wrBeat) && (cntReg == CNT_LAST);

    assign mem_valid = busy;
    assign mem_we    = (stateReg == WR_BURST);
    assign mem_addr  = busy ? {lineReg, cntReg, 2'b00} : '0;
    assign mem_wdata = (stateReg == WR_BURST) ? d_wdata : '0;
    assign d_wpop    = wrBeat;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            stateReg  <= IDLE;
            cntReg    <= '0;
            lineReg   <= '0;
            ownerDReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (grantI || grantD) begin
                        lineReg   <= reqLine;
                        ownerDReg <= grantD;
                        cntReg    <= '0;
                        stateReg  <= (grantD && dreq_we) ? WR_BURST : RD_BURST;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (mem_ready) begin
                        cntReg <= cntReg + CNT_ONE;
                        if (lastBeat) begin
                            stateReg <= IDLE;
                        end
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    cntReg   <= '0;
                end
            endcase
        end
    end

    // Channel 0 returns to the I-cache, channel 1 to the D-cache.
    for (genvar gi = 0; gi < 2; gi++) begin : gRespCh
        logic              validReg;
        logic [DATA_W-1:0] dataReg;
        logic              lastReg;
        logic              isOwner;
        logic              ackNow;

        assign isOwner = (ownerDReg == (gi == 1));
        assign ackNow  = (gi == 1) && wrBeat && (cntReg == CNT_LAST);

        always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
            if (!CPU_RST_N) begin
                validReg <= 1'b0;
                dataReg  <= '0;
                lastReg  <= 1'b0;
            end else begin
                validReg <= 1'b0;
                dataReg  <= '0;
                lastReg  <= 1'b0;
                if (rdBeat && isOwner) begin
                    validReg <= 1'b1;
                    dataReg  <= mem_rdata;
                    lastReg  <= (cntReg == CNT_LAST);
                end else if (ackNow) begin
                    validReg <= 1'b1;
                    lastReg  <= 1'b1;
                end
            end
        end
    end

    assign iresp_valid = gRespCh[0].validReg;
    assign iresp_data  = gRespCh[0].dataReg;
    assign iresp_last  = gRespCh[0].lastReg;
    assign dresp_valid = gRespCh[1].validReg;
    assign dresp_data  = gRespCh[1].dataReg;
    assign dresp_last  = gRespCh[1].lastReg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table for a plain I refill,
// plus hand-written sequences for write-back, ties, queued requests, stalls and reset.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        iresp_last;
    logic        dreq_valid;
    logic        dreq_we;
    logic [31:0] dreq_addr;
    logic        dreq_ready;
    logic [31:0] d_wdata;
    logic        d_wpop;
    logic        dresp_valid;
    logic [31:0] dresp_data;
    logic        dresp_last;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int nChecks = 0;
    int nFail   = 0;

    always #5 CPU_CLK = ~CPU_CLK;

    cache_mem_arbiter #(.LINE_WORDS(8), .ADDR_W(32), .DATA_W(32)) dut (
        .CPU_CLK     (CPU_CLK),
        .CPU_RST_N   (CPU_RST_N),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .ireq_ready  (ireq_ready),
        .iresp_valid (iresp_valid),
        .iresp_data  (iresp_data),
        .iresp_last  (iresp_last),
        .dreq_valid  (dreq_valid),
        .dreq_we     (dreq_we),
        .dreq_addr   (dreq_addr),
        .dreq_ready  (dreq_ready),
        .d_wdata     (d_wdata),
        .d_wpop      (d_wpop),
        .dresp_valid (dresp_valid),
        .dresp_data  (dresp_data),
        .dresp_last  (dresp_last),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        mr;
        logic [31:0] rd;
        logic        eIrdy;
        logic        eMv;
        logic [31:0] eMa;
        logic        eIrv;
        logic [31:0] eIrd;
        logic        eIrl;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        CPU_RST_N  = 1'b0;
        ireq_valid = 1'b0;
        ireq_addr  = '0;
        dreq_valid = 1'b0;
        dreq_we    = 1'b0;
        dreq_addr  = '0;
        d_wdata    = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        @(negedge CPU_CLK);
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        @(negedge CPU_CLK);
    endtask

    // Called the cycle after a grant with mem_ready held high; returns inside the
    // cycle that carries the final response, before the next clock edge.
    task automatic readBurst(input logic ownD, input logic [31:0] base, input logic [31:0] seed);
        logic ownV, othV;
        for (int c = 0; c <= 8; c++) begin
            mem_ready = (c < 8);
            mem_rdata = seed + 32'(c);
            #2;
            if (c < 8) begin
                chk($sformatf("rb_mem_valid[%0d]", c), mem_valid, 1'b1);
                chk($sformatf("rb_mem_addr[%0d]", c), mem_addr, base + 32'(4 * c));
                chk($sformatf("rb_mem_we[%0d]", c), mem_we, 1'b0);
                chk($sformatf("rb_iready_wait[%0d]", c), ireq_ready, 1'b0);
                chk($sformatf("rb_dready_wait[%0d]", c), dreq_ready, 1'b0);
            end else begin
                chk("rb_mem_valid_end", mem_valid, 1'b0);
            end
            ownV = ownD ? dresp_valid : iresp_valid;
            othV = ownD ? iresp_valid : dresp_valid;
            chk($sformatf("rb_owner_valid[%0d]", c), ownV, (c >= 1));
            chk($sformatf("rb_other_valid[%0d]", c), othV, 1'b0);
            if (c >= 1) begin
                chk($sformatf("rb_data[%0d]", c), ownD ? dresp_data : iresp_data, seed + 32'(c - 1));
                chk($sformatf("rb_last[%0d]", c), ownD ? dresp_last : iresp_last, (c == 8));
            end
            if (c < 8) @(negedge CPU_CLK);
        end
        $display("[%0t] read burst owner=%s base=0x%08h complete", $time, ownD ? "D" : "I", base);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        expD2;
        int          pops, wpopSeen, ackSeen, respCnt;
        logic        ackDue, burst;

`ifdef CACHE_MEM_ARB_DPRIO_EN
        expD2 = 1'b1;
`else
        expD2 = 1'b0;
`endif

        vecs[0]  = '{1'b1, 32'h0000_1234, 1'b1, 32'hDEAD_0000, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0000, 1'b0, 1'b1, 32'h1220, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0001, 1'b0, 1'b1, 32'h1224, 1'b1, 32'hC0DE_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0002, 1'b0, 1'b1, 32'h1228, 1'b1, 32'hC0DE_0001, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0003, 1'b0, 1'b1, 32'h122C, 1'b1, 32'hC0DE_0002, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0004, 1'b0, 1'b1, 32'h1230, 1'b1, 32'hC0DE_0003, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0005, 1'b0, 1'b1, 32'h1234, 1'b1, 32'hC0DE_0004, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0006, 1'b0, 1'b1, 32'h1238, 1'b1, 32'hC0DE_0005, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 32'hC0DE_0007, 1'b0, 1'b1, 32'h123C, 1'b1, 32'hC0DE_0006, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h0,    1'b1, 32'hC0DE_0007, 1'b1};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    1'b0, 32'h0,         1'b0};

        // Reset state, with requests and mem_ready asserted to show nothing leaks out.
        CPU_RST_N  = 1'b0;
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_1234;
        dreq_valid = 1'b1;
        dreq_we    = 1'b1;
        dreq_addr  = 32'h0000_0080;
        d_wdata    = 32'hFFFF_FFFF;
        mem_rdata  = 32'hFFFF_FFFF;
        mem_ready  = 1'b1;
        @(negedge CPU_CLK);
        #2;
        chk("rst_ireq_ready", ireq_ready, 1'b0);
        chk("rst_dreq_ready", dreq_ready, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_d_wpop", d_wpop, 1'b0);
        chk("rst_iresp_valid", iresp_valid, 1'b0);
        chk("rst_dresp_valid", dresp_valid, 1'b0);
        chk("rst_dresp_last", dresp_last, 1'b0);
        doReset();

        // 1: I-only refill from the vector table.
        for (int i = 0; i < 11; i++) begin
            ireq_valid = vecs[i].iv;
            ireq_addr  = vecs[i].ia;
            mem_ready  = vecs[i].mr;
            mem_rdata  = vecs[i].rd;
            #2;
            chk($sformatf("t1_ireq_ready[%0d]", i), ireq_ready, vecs[i].eIrdy);
            chk($sformatf("t1_mem_valid[%0d]", i), mem_valid, vecs[i].eMv);
            chk($sformatf("t1_mem_addr[%0d]", i), mem_addr, vecs[i].eMa);
            chk($sformatf("t1_mem_we[%0d]", i), mem_we, 1'b0);
            chk($sformatf("t1_iresp_valid[%0d]", i), iresp_valid, vecs[i].eIrv);
            chk($sformatf("t1_iresp_data[%0d]", i), iresp_data, vecs[i].eIrd);
            chk($sformatf("t1_iresp_last[%0d]", i), iresp_last, vecs[i].eIrl);
            chk($sformatf("t1_dresp_valid[%0d]", i), dresp_valid, 1'b0);
            chk($sformatf("t1_dreq_ready[%0d]", i), dreq_ready, 1'b0);
            @(negedge CPU_CLK);
        end
        $display("[%0t] t1 I refill 0x00001234 applied", $time);

        // 2: D write-back, mem_ready toggling 1,0.
        dreq_valid = 1'b1;
        dreq_we    = 1'b1;
        dreq_addr  = 32'h0000_0080;
        d_wdata    = 32'hBEEF_0000;
        #2;
        chk("t2_dreq_ready", dreq_ready, 1'b1);
        chk("t2_mem_valid_grant", mem_valid, 1'b0);
        @(negedge CPU_CLK);
        dreq_valid = 1'b0;
        pops = 0; wpopSeen = 0; ackSeen = 0; ackDue = 1'b0;
        for (int c = 0; c < 20; c++) begin
            mem_ready = (c % 2 == 0);
            d_wdata   = 32'hBEEF_0000 + 32'(pops);
            #2;
            burst = (pops < 8);
            chk($sformatf("t2_mem_valid[%0d]", c), mem_valid, burst);
            if (burst) begin
                chk($sformatf("t2_mem_addr[%0d]", c), mem_addr, 32'h80 + 32'(4 * pops));
                chk($sformatf("t2_mem_we[%0d]", c), mem_we, 1'b1);
                chk($sformatf("t2_mem_wdata[%0d]", c), mem_wdata, 32'hBEEF_0000 + 32'(pops));
            end
            chk($sformatf("t2_d_wpop[%0d]", c), d_wpop, burst && mem_ready);
            chk($sformatf("t2_dresp_valid[%0d]", c), dresp_valid, ackDue);
            if (ackDue) begin
                chk("t2_dresp_last", dresp_last, 1'b1);
                chk("t2_dresp_data", dresp_data, 32'h0);
            end
            chk($sformatf("t2_iresp_valid[%0d]", c), iresp_valid, 1'b0);
            wpopSeen += int'(d_wpop);
            if (dresp_valid && dresp_last) ackSeen++;
            ackDue = 1'b0;
            if (burst && mem_ready) begin
                pops++;
                if (pops == 8) ackDue = 1'b1;
            end
            @(negedge CPU_CLK);
        end
        chk("t2_wpop_count", 32'(wpopSeen), 32'd8);
        chk("t2_ack_count", 32'(ackSeen), 32'd1);
        $display("[%0t] t2 D write-back 0x00000080 applied", $time);

        // 3: I and D tied twice in a row, starting from reset arbitration state.
        doReset();
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_2004;
        dreq_valid = 1'b1;
        dreq_we    = 1'b0;
        dreq_addr  = 32'h0000_3010;
        #2;
        chk("t3_tie1_dready", dreq_ready, 1'b1);
        chk("t3_tie1_iready", ireq_ready, 1'b0);
        @(negedge CPU_CLK);
        dreq_valid = 1'b0;
        readBurst(1'b1, 32'h0000_3000, 32'hD300_0000);
        dreq_valid = 1'b1;
        dreq_addr  = 32'h0000_3020;
        #1;
        chk("t3_tie2_dready", dreq_ready, expD2);
        chk("t3_tie2_iready", ireq_ready, !expD2);
        @(negedge CPU_CLK);
        if (expD2) dreq_valid = 1'b0;
        else       ireq_valid = 1'b0;
        readBurst(expD2, expD2 ? 32'h0000_3020 : 32'h0000_2000, 32'hD320_0000);
        chk("t3_waiting_side_ready", expD2 ? ireq_ready : dreq_ready, 1'b1);
        @(negedge CPU_CLK);
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        readBurst(!expD2, expD2 ? 32'h0000_2000 : 32'h0000_3020, 32'hD340_0000);
        @(negedge CPU_CLK);

        // 4: D request arriving during an I burst waits for the idle bubble.
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_4008;
        #2;
        chk("t4_ireq_ready", ireq_ready, 1'b1);
        @(negedge CPU_CLK);
        ireq_valid = 1'b0;
        dreq_valid = 1'b1;
        dreq_we    = 1'b0;
        dreq_addr  = 32'h0000_5004;
        readBurst(1'b0, 32'h0000_4000, 32'h4400_0000);
        chk("t4_dready_bubble", dreq_ready, 1'b1);
        chk("t4_iready_bubble", ireq_ready, 1'b0);
        @(negedge CPU_CLK);
        dreq_valid = 1'b0;
        readBurst(1'b1, 32'h0000_5000, 32'h5500_0000);
        @(negedge CPU_CLK);

        // 6: 20-cycle memory stall after three beats.
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_6018;
        #2;
        chk("t6_ireq_ready", ireq_ready, 1'b1);
        @(negedge CPU_CLK);
        ireq_valid = 1'b0;
        respCnt = 0;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            mem_rdata = 32'h6000_0000 + 32'(c);
            #2;
            chk($sformatf("t6_pre_addr[%0d]", c), mem_addr, 32'h6000 + 32'(4 * c));
            respCnt += int'(iresp_valid);
            @(negedge CPU_CLK);
        end
        for (int s = 0; s < 20; s++) begin
            mem_ready = 1'b0;
            mem_rdata = 32'hFFFF_FFFF;
            #2;
            chk($sformatf("t6_stall_valid[%0d]", s), mem_valid, 1'b1);
            chk($sformatf("t6_stall_addr[%0d]", s), mem_addr, 32'h0000_600C);
            chk($sformatf("t6_stall_resp[%0d]", s), iresp_valid, (s == 0));
            respCnt += int'(iresp_valid);
            @(negedge CPU_CLK);
        end
        for (int c = 3; c < 8; c++) begin
            mem_ready = 1'b1;
            mem_rdata = 32'h6000_0000 + 32'(c);
            #2;
            chk($sformatf("t6_post_addr[%0d]", c), mem_addr, 32'h6000 + 32'(4 * c));
            chk($sformatf("t6_post_valid[%0d]", c), mem_valid, 1'b1);
            respCnt += int'(iresp_valid);
            @(negedge CPU_CLK);
        end
        mem_ready = 1'b0;
        #2;
        chk("t6_final_valid", iresp_valid, 1'b1);
        chk("t6_final_last", iresp_last, 1'b1);
        chk("t6_final_data", iresp_data, 32'h6000_0007);
        chk("t6_final_mem_valid", mem_valid, 1'b0);
        respCnt += int'(iresp_valid);
        @(negedge CPU_CLK);
        chk("t6_resp_count", 32'(respCnt), 32'd8);
        $display("[%0t] t6 stalled I refill 0x00006018 applied", $time);

        // 5: reset asserted during beat 3 of a read.
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_7000;
        #2;
        chk("t5_ireq_ready", ireq_ready, 1'b1);
        @(negedge CPU_CLK);
        ireq_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            mem_rdata = 32'h7000_0000 + 32'(c);
            #2;
            chk($sformatf("t5_addr[%0d]", c), mem_addr, 32'h7000 + 32'(4 * c));
            @(negedge CPU_CLK);
        end
        mem_ready = 1'b1;
        d_wdata   = 32'h1234_5678;
        #1;
        chk("t5_beat3_addr", mem_addr, 32'h0000_700C);
        chk("t5_beat3_resp", iresp_valid, 1'b1);
        CPU_RST_N = 1'b0;
        #1;
        chk("t5_rst_mem_valid", mem_valid, 1'b0);
        chk("t5_rst_mem_addr", mem_addr, 32'h0);
        chk("t5_rst_mem_we", mem_we, 1'b0);
        chk("t5_rst_mem_wdata", mem_wdata, 32'h0);
        chk("t5_rst_iresp_valid", iresp_valid, 1'b0);
        chk("t5_rst_iresp_data", iresp_data, 32'h0);
        chk("t5_rst_iresp_last", iresp_last, 1'b0);
        chk("t5_rst_dresp_valid", dresp_valid, 1'b0);
        chk("t5_rst_d_wpop", d_wpop, 1'b0);
        chk("t5_rst_ready", {ireq_ready, dreq_ready}, 2'b00);
        @(negedge CPU_CLK);
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        @(negedge CPU_CLK);
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hAAAA_0000 + 32'(c);
            #2;
            chk($sformatf("t5_post_mem_valid[%0d]", c), mem_valid, 1'b0);
            chk($sformatf("t5_post_iresp[%0d]", c), iresp_valid, 1'b0);
            chk($sformatf("t5_post_dresp[%0d]", c), dresp_valid, 1'b0);
            @(negedge CPU_CLK);
        end
        $display("[%0t] t5 reset during I refill 0x00007000 applied", $time);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
